// File: rtl/display_pkg.sv
// Shared display types and helpers for the BCD scan counter.
// Digit codes, blank code and one-hot digit-select helper.
package display_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_BLANK = 4'hF;
   localparam bcd_t BCD_MAX   = 4'd9;

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle of the BCD scan counter.
// master = counter side, slave = board/driver side.
interface bcd_scan_counter_if
   import display_pkg::*;
#(
   parameter int DIGITS = 3
);

   logic                  en;
   logic                  up_dn;
   logic                  clr;
   logic                  lz_blank;
   bcd_t                  bcd_out;
   logic [DIGITS-1:0]     digit_sel;
   logic                  blinky;
   logic                  wrap;
   logic [4*DIGITS-1:0]   value_bcd;

   modport master (
      input  en, up_dn, clr, lz_blank,
      output bcd_out, digit_sel, blinky, wrap, value_bcd
   );

   modport slave (
      output en, up_dn, clr, lz_blank,
      input  bcd_out, digit_sel, blinky, wrap, value_bcd
   );

endinterface

// File: rtl/bcd_digit.sv
// One decade of the counter: 0..9 register with ripple carry/borrow.
// carry_out/borrow_out are combinational so a whole chain settles in one cycle.
module bcd_digit
   import display_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   input  logic dec,
   input  logic carry_in,
   input  logic borrow_in,
   output bcd_t q,
   output logic carry_out,
   output logic borrow_out
);

   assign carry_out  = carry_in  & (q == BCD_MAX);
   assign borrow_out = borrow_in & (q == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc & carry_in) begin
         q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      end else if (dec & borrow_in) begin
         q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with multiplexed 4511-style display drive.
// Count and scan rates come from clock-enable prescalers on clk.
module bcd_scan_counter
   import display_pkg::*;
#(
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 4096,
   parameter int TICK_DIV = 262144
)(
   input  logic clk,
   input  logic rst_n,
   bcd_scan_counter_if.master bus
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [TW-1:0] tcnt;
   logic [SW-1:0] scnt;
   logic          tick;
   logic          strobe;
   logic          step_up;
   logic          step_dn;
   logic [DIGITS:0] carry;
   logic [DIGITS:0] borrow;
   bcd_t          dq [DIGITS];
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_n;
   logic [DIGITS-1:0] upz;
   logic          blank;

   assign tick   = (tcnt == TW'(TICK_DIV - 1));
   assign strobe = (scnt == SW'(SCAN_DIV - 1));

   // Clear restarts the count period so the next step is a full tick away
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
         scnt <= '0;
      end else begin
         tcnt <= (bus.clr || tick) ? '0 : tcnt + TW'(1);
         scnt <= strobe ? '0 : scnt + SW'(1);
      end
   end

   assign step_up = tick & bus.en & bus.up_dn & ~bus.clr;
   assign step_dn = tick & bus.en & ~bus.up_dn & ~bus.clr;
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_digit u_dig (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr        (bus.clr),
         .inc        (step_up),
         .dec        (step_dn),
         .carry_in   (carry[k]),
         .borrow_in  (borrow[k]),
         .q          (dq[k]),
         .carry_out  (carry[k+1]),
         .borrow_out (borrow[k+1])
      );
      assign bus.value_bcd[4*k +: 4] = dq[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.blinky <= 1'b0;
         bus.wrap   <= 1'b0;
      end else begin
         bus.blinky <= bus.blinky ^ tick;
         bus.wrap   <= (step_up & carry[DIGITS])
                     | (step_dn & borrow[DIGITS]);
      end
   end

   always_comb begin
      idx_n = idx;
      if (strobe)
         idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   end

   // upz[k]: digit k and everything above it are zero
   always_comb begin
      upz = '0;
      upz[DIGITS-1] = (dq[DIGITS-1] == 4'd0);
      for (int k = DIGITS - 2; k >= 0; k--)
         upz[k] = upz[k+1] & (dq[k] == 4'd0);
   end

   assign blank = bus.lz_blank & (idx_n != '0) & upz[idx_n];

   // bcd_out uses the next index so it lands on the same edge as digit_sel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx           <= '0;
         bus.digit_sel <= DIGITS'(1);
         bus.bcd_out   <= 4'd0;
      end else begin
         idx           <= idx_n;
         bus.digit_sel <= DIGITS'(onehot(3'(idx_n)));
         bus.bcd_out   <= blank ? BCD_BLANK : dq[idx_n];
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (DIGITS=3, SCAN_DIV=4, TICK_DIV=8).
// Reference keeps the count as a plain integer and derives display codes arithmetically.
module tb_bcd_scan_counter;

   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;
   localparam int TICK_DIV = 8;
   localparam int MODV     = 1000;

   bit clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bcd_scan_counter_if #(.DIGITS(DIGITS)) bus ();

   bcd_scan_counter #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int nvec = 0;
   int nerr = 0;
   int ntog = 0;
   logic prev_blink = 1'b0;
   logic [2:0] prev_sel;

   int m_tp = 0;
   int m_sp = 0;
   int m_cnt = 0;
   int m_idx = 0;
   bit m_blink = 1'b0;
   bit m_wrap = 1'b0;
   bit [3:0] m_bcd = 4'd0;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic bit [3:0] disp(input int i, input int v, input bit lz);
      int pw = 1;
      for (int k = 0; k < i; k++) pw = pw * 10;
      if (lz && i > 0 && v < pw) return 4'hF;
      return 4'((v / pw) % 10);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tp <= 0; m_sp <= 0; m_cnt <= 0; m_idx <= 0;
         m_blink <= 1'b0; m_wrap <= 1'b0; m_bcd <= 4'd0;
      end else begin
         automatic bit tk = (m_tp == TICK_DIV - 1);
         automatic bit ss = (m_sp == SCAN_DIV - 1);
         automatic int ni = ss ? (m_idx + 1) % DIGITS : m_idx;
         m_tp <= (bus.clr || tk) ? 0 : m_tp + 1;
         m_sp <= ss ? 0 : m_sp + 1;
         if (tk) m_blink <= !m_blink;
         m_wrap <= 1'b0;
         if (bus.clr) m_cnt <= 0;
         else if (tk && bus.en) begin
            if (bus.up_dn) begin
               m_cnt  <= (m_cnt + 1) % MODV;
               m_wrap <= (m_cnt == MODV - 1);
            end else begin
               m_cnt  <= (m_cnt + MODV - 1) % MODV;
               m_wrap <= (m_cnt == 0);
            end
         end
         m_idx <= ni;
         m_bcd <= disp(ni, m_cnt, bus.lz_blank);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("value_bcd", 32'(bus.value_bcd), 32'(to_bcd(m_cnt)));
      chk("digit_sel", 32'(bus.digit_sel), 32'(1) << m_idx);
      chk("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
      chk("blinky", 32'(bus.blinky), 32'(m_blink));
      chk("wrap", 32'(bus.wrap), 32'(m_wrap));
   endtask

   task automatic cyc();
      @(negedge clk);
      if (bus.blinky !== prev_blink) ntog++;
      prev_blink = bus.blinky;
      check_all();
   endtask

   task automatic wait_tick_edge();
      int g = 0;
      while (m_tp != TICK_DIV - 1 && g < 64) begin
         cyc();
         g++;
      end
      if (g >= 64) chk("tick_timeout", 32'(g), 32'(0));
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         wait_tick_edge();
         cyc();
      end
   endtask

   task automatic do_clr();
      bus.clr = 1'b1;
      cyc();
      bus.clr = 1'b0;
   endtask

   task automatic slots(input bit [3:0] e0, input bit [3:0] e1,
                        input bit [3:0] e2);
      cyc();
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk("lz_onehot", 32'($onehot(bus.digit_sel)), 32'(1));
         case (bus.digit_sel)
            3'b001:  chk("lz_d0", 32'(bus.bcd_out), 32'(e0));
            3'b010:  chk("lz_d1", 32'(bus.bcd_out), 32'(e1));
            3'b100:  chk("lz_d2", 32'(bus.bcd_out), 32'(e2));
            default: ;
         endcase
      end
   endtask

   initial begin
      int t0;
      int run;
      int changes;
      bus.en = 1'b0; bus.up_dn = 1'b1; bus.clr = 1'b0; bus.lz_blank = 1'b0;

      // reset held for 3 cycles, then count to 042 and reset mid-slot
      repeat (3) cyc();
      rst_n = 1'b1;
      bus.en = 1'b1;
      tick_n(42);
      chk("cnt42", 32'(bus.value_bcd), 32'h042);
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_value", 32'(bus.value_bcd), 32'h000);
      chk("arst_sel", 32'(bus.digit_sel), 32'b001);
      chk("arst_bcd", 32'(bus.bcd_out), 32'h0);
      chk("arst_blinky", 32'(bus.blinky), 32'h0);
      chk("arst_wrap", 32'(bus.wrap), 32'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      ntog = 0;

      // full up count with wrap
      tick_n(999);
      chk("up_999", 32'(bus.value_bcd), 32'h999);
      tick_n(1);
      chk("up_wrap_val", 32'(bus.value_bcd), 32'h000);
      chk("up_wrap_hi", 32'(bus.wrap), 32'h1);
      cyc();
      chk("up_wrap_lo", 32'(bus.wrap), 32'h0);
      chk("blink_1000", 32'(ntog), 32'd1000);

      // carry and borrow across decades
      tick_n(99);
      chk("up_099", 32'(bus.value_bcd), 32'h099);
      tick_n(1);
      chk("up_100", 32'(bus.value_bcd), 32'h100);
      bus.up_dn = 1'b0;
      tick_n(1);
      chk("dn_099", 32'(bus.value_bcd), 32'h099);
      tick_n(99);
      chk("dn_000", 32'(bus.value_bcd), 32'h000);
      tick_n(1);
      chk("dn_wrap_val", 32'(bus.value_bcd), 32'h999);
      chk("dn_wrap_hi", 32'(bus.wrap), 32'h1);

      // leading-zero blanking
      bus.up_dn = 1'b1;
      do_clr();
      tick_n(5);
      bus.en = 1'b0;
      bus.lz_blank = 1'b1;
      slots(4'h5, 4'hF, 4'hF);
      do_clr();
      slots(4'h0, 4'hF, 4'hF);
      bus.en = 1'b1;
      tick_n(105);
      bus.en = 1'b0;
      chk("cnt105", 32'(bus.value_bcd), 32'h105);
      slots(4'h5, 4'h0, 4'h1);
      do_clr();
      bus.en = 1'b1;
      tick_n(5);
      bus.en = 1'b0;
      bus.lz_blank = 1'b0;
      slots(4'h5, 4'h0, 4'h0);

      // clear coinciding with a tick, then hold with en=0
      bus.en = 1'b1;
      do_clr();
      tick_n(57);
      chk("cnt57", 32'(bus.value_bcd), 32'h057);
      wait_tick_edge();
      t0 = ntog;
      bus.clr = 1'b1;
      cyc();
      bus.clr = 1'b0;
      chk("clr_tick_val", 32'(bus.value_bcd), 32'h000);
      chk("clr_tick_wrap", 32'(bus.wrap), 32'h0);
      chk("clr_tick_blink", 32'(ntog - t0), 32'd1);
      tick_n(3);
      bus.en = 1'b0;
      t0 = ntog;
      tick_n(5);
      chk("hold_val", 32'(bus.value_bcd), 32'h003);
      chk("hold_blink", 32'(ntog - t0), 32'd5);

      // scan rotation
      prev_sel = bus.digit_sel;
      run = 0;
      changes = 0;
      for (int k = 0; k < 24; k++) begin
         cyc();
         run++;
         chk("scan_onehot", 32'($onehot(bus.digit_sel)), 32'(1));
         if (bus.digit_sel !== prev_sel) begin
            chk("scan_rot", 32'(bus.digit_sel),
                32'({prev_sel[1:0], prev_sel[2]}));
            if (changes > 0) chk("scan_hold", 32'(run), 32'd4);
            changes++;
            run = 0;
            prev_sel = bus.digit_sel;
         end
      end
      chk("scan_changes", 32'(changes), 32'd6);

      // randomized traffic against the reference
      for (int k = 0; k < 1500; k++) begin
         bus.en       = ($urandom_range(0, 3) != 0);
         bus.up_dn    = 1'($urandom_range(0, 1));
         bus.lz_blank = 1'($urandom_range(0, 1));
         bus.clr      = ($urandom_range(0, 63) == 0);
         cyc();
      end
      bus.clr = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised N-digit BCD up/down counter with a time-multiplexed display driver for one 4511-style BCD-to-7-seg decoder and one-hot digit-select transistors.
- Derives its count and scan rates from `clk` using clock-enable prescalers; it creates no derived clocks.
- Adds enable, direction, synchronous clear, leading-zero blanking, a wrap pulse and a parallel BCD value output.
- Sits directly between the board clock and the display pins; the successor to the fixed 3-digit up-only counter.

Parameters:
- DIGITS, 3, number of decades (legal 1..8).
- SCAN_DIV, 4096, clk cycles per digit scan slot (>=2).
- TICK_DIV, 262144, clk cycles per count step (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable, sampled on tick cycles.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear of the count value.
- lz_blank  in  1  1 = blank leading zeros.
- bcd_out  out  4  BCD code to decoder; 4'hF means blank.
- digit_sel  out  DIGITS  one-hot digit transistor enable; bit 0 = least significant digit.
- blinky  out  1  toggles on every tick.
- wrap  out  1  one-cycle pulse on wrap-around.
- value_bcd  out  4*DIGITS  current count, digit k at bits [4k+3:4k].

Behaviour:
- **Reset (rst_n=0, asynchronous, any time incl. mid-slot or mid-tick):**
  - Outputs: all digits 0, value_bcd=0, scan index 0, digit_sel=1, bcd_out=0, blinky=0, wrap=0.
  - Both prescalers are set to 0.
  - Release is synchronous to the next clk edge.
- **Tick prescaler:**
  - Counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle when it equals TICK_DIV-1.
  - Width is clog2(TICK_DIV).
  - Runs regardless of en.
- **Scan prescaler:** same scheme with SCAN_DIV, producing a scan strobe.
- **Count update (registered on the tick cycle):**
  - Priority 1: clr=1 (any cycle, tick or not) sets all digits to 0 and the tick prescaler to 0; no wrap.
  - Priority 2: tick & en & up_dn: digit0+1. A digit at 9 becomes 0 and carries into the next digit, rippling through all digits in the same cycle.
  - Priority 3: tick & en & ~up_dn: digit0-1. A digit at 0 becomes 9 and borrows from the next digit.
  - Otherwise hold.
- **Digit range:** a digit is never outside 0..9; the result is valid on the edge following the tick.
- **wrap:**
  - Up: all-9s to all-0s.
  - Down: all-0s to all-9s.
  - Asserted for exactly the one cycle after that update edge.
  - Never asserted on clr.
- **blinky:** toggles on every tick, independent of en and clr.
- **value_bcd:** direct register view of the digits; 1 cycle after the tick edge.
- **Scan:**
  - On the scan strobe, the index advances 0,1,..,DIGITS-1,0.
  - digit_sel is the registered one-hot of the index; exactly one bit is high at all times after reset.
- **bcd_out:**
  - Registered every cycle from the current index and current digits.
  - digit_sel and bcd_out change on the same edge, and bcd_out reflects a count change within 1 cycle.
- **Blanking:**
  - If lz_blank=1, the index is >0, and that digit plus all more-significant digits are 0, then bcd_out=4'hF.
  - Digit 0 is never blanked, so a count of 0 shows "0".
- **DIGITS=1:** digit_sel is a constant 1 and the scan index stays 0.

Decomposition:
- Shared package `display_pkg`:
  - typedef bcd_t (4-bit).
  - Constant BCD_BLANK=4'hF.
  - Constant BCD_MAX=4'd9.
  - Function `onehot(idx)`.
- Sub-module `bcd_digit`:
  - One decade register with inc/dec/clr inputs, carry_in/borrow_in, and carry_out/borrow_out (combinational from the current value and direction).
  - Instantiated DIGITS times by a generate loop.

Test Plan:
All scenarios use DIGITS=3, SCAN_DIV=4, TICK_DIV=8.
1. Assert rst_n=0 for 3 cycles, release, then assert rst_n=0 again mid-scan-slot with the count at 042 -> asynchronously value_bcd=0, digit_sel=3'b001, bcd_out=0, blinky=0, wrap=0.
2. Set en=1, up_dn=1 and run 999 ticks -> value_bcd=12'h999; next tick -> 12'h000 with wrap high for exactly 1 cycle; blinky toggled 1000 times.
3. Count to 099 then 1 tick up -> 12'h100; then set up_dn=0 and 1 tick -> 12'h099; from 000, 1 tick down -> 12'h999 with a wrap pulse.
4. Count at 005, lz_blank=1, observe 3 scan slots -> sel 001: bcd_out 5; sel 010: F; sel 100: F. Count 000 -> digit0 shows 0, others F. Count 105 -> 5, 0, 1 (inner zero not blanked). lz_blank=0 -> 5, 0, 0 for 005.
5. Count at 057, assert clr together with a tick and en=1 -> value_bcd=0, no wrap. With en=0 for 5 ticks -> value held, blinky still toggles 5 times.
6. Scan check over 24 cycles -> digit_sel sequence 001, 010, 100 with each value held 4 cycles, always one-hot, and bcd_out aligned to the same edge as digit_sel.
